// File: rtl/icache_dm_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module  : icache_dm_if
// Brief   : core-side instruction fetch bus (request, response, fence.i flush)
// Revision: 1.0
// -----------------------------------------------------------------------------
interface icache_dm_if #(
  parameter int ADDRW = 32,
  parameter int DATAW = 32
) ();
  logic             core_valid_i;
  logic [ADDRW-1:0] core_addr_i;
  logic             core_ready_o;
  logic             core_resp_o;
  logic [DATAW-1:0] core_rdata_o;
  logic             flush_i;

  modport master (
    output core_valid_i, core_addr_i, flush_i,
    input  core_ready_o, core_resp_o, core_rdata_o
  );

  modport slave (
    input  core_valid_i, core_addr_i, flush_i,
    output core_ready_o, core_resp_o, core_rdata_o
  );
endinterface
`default_nettype wire

// File: rtl/icache_dm.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module  : icache_dm
// Brief   : direct-mapped read-only instruction cache, word-by-word line refill
// Revision: 1.0
// -----------------------------------------------------------------------------
module icache_dm #(
  parameter int ADDRW      = 32,
  parameter int DATAW      = 32,
  parameter int NUM_LINES  = 64,
  parameter int LINE_WORDS = 4
) (
  input  wire logic             clk_i,
  input  wire logic             rst_ni,
  icache_dm_if.slave            core,
  output logic                  mem_req_o,
  output logic [ADDRW-1:0]      mem_addr_o,
  input  wire logic             mem_gnt_i,
  input  wire logic             mem_rvalid_i,
  input  wire logic [DATAW-1:0] mem_rdata_i
);

  localparam int c_offw = $clog2(LINE_WORDS);
  localparam int c_idxw = $clog2(NUM_LINES);
  localparam int c_tagw = ADDRW - c_idxw - c_offw - 2;
  localparam logic [c_offw-1:0] c_last_word = c_offw'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    LOOKUP      = 3'd1,
    REFILL_REQ  = 3'd2,
    REFILL_WAIT = 3'd3,
    REPLAY      = 3'd4
  } state_t;

  state_t r_state, w_state_nxt;

  logic [ADDRW-1:0]  r_req_addr;
  logic [NUM_LINES-1:0] r_valid;
  logic [c_tagw-1:0] r_tag  [NUM_LINES];
  logic [DATAW-1:0]  r_data [NUM_LINES*LINE_WORDS];
  logic [c_offw-1:0] r_cnt;
  logic              r_flush_pend;
  logic [DATAW-1:0]  r_rdata_hold;

  logic [c_offw-1:0] w_off;
  logic [c_idxw-1:0] w_idx;
  logic [c_tagw-1:0] w_tag;
  logic              w_hit;
  logic [DATAW-1:0]  w_rd_word;
  logic              w_ready, w_resp, w_accept, w_miss, w_beat, w_fill_done, w_mem_req;
  logic              w_unused;

  assign w_off     = r_req_addr[c_offw+1:2];
  assign w_idx     = r_req_addr[c_offw+c_idxw+1:c_offw+2];
  assign w_tag     = r_req_addr[ADDRW-1:ADDRW-c_tagw];
  assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_rd_word = r_data[{w_idx, w_off}];
  assign w_accept  = w_ready && core.core_valid_i;
  assign w_unused  = ^r_req_addr[1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_resp      = 1'b0;
    w_miss      = 1'b0;
    w_beat      = 1'b0;
    w_fill_done = 1'b0;
    w_mem_req   = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (core.core_valid_i) w_state_nxt = LOOKUP;
      end
      LOOKUP: begin
        if (w_hit) begin
          w_resp      = 1'b1;
          w_ready     = 1'b1;
          w_state_nxt = core.core_valid_i ? LOOKUP : IDLE;
        end else begin
          w_miss      = 1'b1;
          w_state_nxt = REFILL_REQ;
        end
      end
      REFILL_REQ: begin
        w_mem_req = 1'b1;
        if (mem_gnt_i) w_state_nxt = REFILL_WAIT;
      end
      REFILL_WAIT: begin
        if (mem_rvalid_i) begin
          w_beat = 1'b1;
          if (r_cnt == c_last_word) begin
            w_fill_done = 1'b1;
            w_state_nxt = REPLAY;
          end else begin
            w_state_nxt = REFILL_REQ;
          end
        end
      end
      REPLAY: begin
        w_resp      = 1'b1;
        w_ready     = 1'b1;
        w_state_nxt = core.core_valid_i ? LOOKUP : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_req_addr   <= '0;
      r_valid      <= '0;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
      r_rdata_hold <= '0;
    end else begin
      if (w_accept) r_req_addr <= core.core_addr_i;
      if (w_miss) begin
        r_valid[w_idx] <= 1'b0;
        r_cnt          <= '0;
      end
      if (w_beat && !w_fill_done) r_cnt <= r_cnt + 1'b1;
      // A flush seen at any point of the refill keeps the new line invalid.
      if (w_fill_done && !(r_flush_pend || core.flush_i)) r_valid[w_idx] <= 1'b1;
      if (core.flush_i) r_valid <= '0;
      if (r_state == REPLAY)
        r_flush_pend <= 1'b0;
      else if (core.flush_i && (r_state == REFILL_REQ || r_state == REFILL_WAIT))
        r_flush_pend <= 1'b1;
      if (w_resp) r_rdata_hold <= w_rd_word;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_beat)      r_data[{w_idx, r_cnt}] <= mem_rdata_i;
    if (w_fill_done) r_tag[w_idx]           <= w_tag;
  end

  assign core.core_ready_o = w_ready;
  assign core.core_resp_o  = w_resp;
  assign core.core_rdata_o = w_resp ? w_rd_word : r_rdata_hold;
  assign mem_req_o         = w_mem_req;
  assign mem_addr_o        = w_mem_req ? {w_tag, w_idx, r_cnt, 2'b00} : '0;

endmodule
`default_nettype wire
